// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage between the PC/branch stage and the decoder.
// It accepts one PC at a time, issues a single-word read to instruction
// memory over a req/ack handshake and holds the returned instruction,
// tagged with its PC, until the decoder consumes it. A misaligned PC is
// turned into a fault entry without touching memory, and a memory that
// never acknowledges is abandoned after TIMEOUT_CYCLES cycles with a
// fetch_error entry. Only one fetch is ever outstanding.
//
// Parameters:
//   NOP_INSTR       instruction presented when no fetched data exists
//   TIMEOUT_CYCLES  cycles spent waiting for mem_ack before giving up (1..255)
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pc_in        fetch address from the branch stage
//   pc_valid     pc_in valid this cycle
//   pc_ready     fetch accepts pc_in this cycle (combinational)
//   flush        redirect: discard the in-flight or held instruction
//   mem_req      memory read request
//   mem_addr     memory byte address, word aligned
//   mem_ack      memory response valid, mem_rdata sampled on the same edge
//   mem_rdata    memory read data
//   instr        fetched instruction
//   instr_pc     PC of instr
//   instr_valid  instr/instr_pc valid for the decoder
//   instr_ready  decoder consumes instr this cycle
//   misaligned   held entry is a misaligned-PC fault
//   fetch_error  held entry is a memory-timeout fault
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // Last timer value on which a missing ack is still tolerated.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q,       state_d;
    logic        mem_req_q,     mem_req_d;
    logic [31:0] mem_addr_q,    mem_addr_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misaligned_q,  misaligned_d;
    logic        fetch_error_q, fetch_error_d;
    logic [7:0]  timer_q,       timer_d;

    logic        pc_ready_s;
    logic        pc_take_s;
    logic        timer_expired_s;
    logic [7:0]  timer_inc_s;

    assign pc_ready_s = (state_q == S_IDLE) && !flush;
    assign pc_take_s  = pc_valid && pc_ready_s;

    // A flush on the very last tolerated cycle moves to DROP with the timer
    // already past TIMEOUT_LAST, so expiry is a >= test rather than ==.
    assign timer_expired_s = (timer_q >= TIMEOUT_LAST);
    assign timer_inc_s     = (timer_q == 8'hFF) ? 8'hFF : (timer_q + 8'd1);

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misaligned_d  = misaligned_q;
        fetch_error_d = fetch_error_q;
        timer_d       = timer_q;

        case (state_q)
            S_IDLE: begin
                if (pc_take_s) begin
                    if (pc_in[1:0] != 2'b00) begin
                        // Fault entry straight to the decoder, no memory access.
                        state_d       = S_HOLD;
                        instr_d       = NOP_INSTR;
                        instr_pc_d    = pc_in;
                        instr_valid_d = 1'b1;
                        misaligned_d  = 1'b1;
                        fetch_error_d = 1'b0;
                    end else begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_in;
                        instr_pc_d = pc_in;
                        timer_d    = 8'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_REQ: begin
                if (flush && mem_ack) begin
                    // Response arrives with the redirect: nothing left in flight.
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end else if (flush) begin
                    // Keep requesting so the outstanding read completes cleanly.
                    state_d = S_DROP;
                    timer_d = timer_inc_s;
                end else if (mem_ack) begin
                    state_d       = S_HOLD;
                    mem_req_d     = 1'b0;
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    misaligned_d  = 1'b0;
                    fetch_error_d = 1'b0;
                end else if (timer_expired_s) begin
                    state_d       = S_HOLD;
                    mem_req_d     = 1'b0;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b1;
                    misaligned_d  = 1'b0;
                    fetch_error_d = 1'b1;
                end else begin
                    timer_d = timer_inc_s;
                end
            end

            S_HOLD: begin
                // Consumption and redirect are the same single exit.
                if (instr_ready || flush) begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                    misaligned_d  = 1'b0;
                    fetch_error_d = 1'b0;
                end else begin
                    state_d = S_HOLD;
                end
            end

            S_DROP: begin
                // Flush is meaningless here: the result is discarded anyway.
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end else if (timer_expired_s) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    timer_d = timer_inc_s;
                end
            end

            default: begin
                state_d       = S_IDLE;
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
                misaligned_d  = 1'b0;
                fetch_error_d = 1'b0;
                timer_d       = 8'd0;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_error_q <= 1'b0;
            timer_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misaligned_q  <= misaligned_d;
            fetch_error_q <= fetch_error_d;
            timer_q       <= timer_d;
        end
    end

    assign pc_ready    = pc_ready_s;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign misaligned  = misaligned_q;
    assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Transaction-level bench for fetch_unit. A driver process plays both the
// branch stage and the instruction memory; for each fetch it picks an ack
// delay, an optional flush point and a decoder back-pressure length, works
// out from the fetch rules what the decoder should receive (if anything) and
// pushes that into a scoreboard queue. A separate monitor pops an entry every
// time instr_valid rises and checks the entry stays stable while held.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          T   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NEVER = 99;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misaligned;
    logic        fetch_error;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    fetch_unit #(
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .misaligned  (misaligned),
        .fetch_error (fetch_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on every new decoder entry, then require it to stay put.
    initial begin
        logic prev_valid;
        exp_t held;
        prev_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (instr_valid) begin
                    if (!prev_valid) begin
                        if (sb.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_valid: got instr_valid=1 pc=%h required no entry", instr_pc);
                        end else begin
                            held = sb.pop_front();
                            check("instr",       instr,                held.instr);
                            check("instr_pc",    instr_pc,             held.pc);
                            check("misaligned",  32'(misaligned),      32'(held.mis));
                            check("fetch_error", 32'(fetch_error),     32'(held.err));
                        end
                    end else begin
                        check("hold_instr",    instr,              held.instr);
                        check("hold_instr_pc", instr_pc,           held.pc);
                        check("hold_flags",    {30'd0, misaligned, fetch_error}, {30'd0, held.mis, held.err});
                    end
                end else begin
                    check("flags_idle", {30'd0, misaligned, fetch_error}, 32'd0);
                end
                prev_valid = instr_valid;
            end
        end
    end

    task automatic idle_inputs();
        pc_valid    = 1'b0;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        mem_rdata   = $urandom;
    endtask

    // One fetch. d: REQ cycle carrying the ack, f: REQ cycle carrying the
    // flush, rdelay: decoder stall cycles, rel: 0 ready, 1 flush, 2 both.
    task automatic run_txn(input logic [31:0] pc, input int d, input int f,
                           input logic [31:0] rdata, input int rdelay,
                           input int rel, input bit pre_flush);
        bit hold     = 1'b0;
        bit dropping = 1'b0;
        bit done     = 1'b0;
        int k        = 0;
        if (pre_flush) begin
            @(negedge clock);
            idle_inputs();
            pc_valid = 1'b1;
            flush    = 1'b1;
            pc_in    = $urandom;
            #1 check("pc_ready_flush", 32'(pc_ready), 32'd0);
        end
        @(negedge clock);
        idle_inputs();
        pc_valid = 1'b1;
        pc_in    = pc;
        #1 check("pc_ready_idle", 32'(pc_ready), 32'd1);
        if (pc[1:0] != 2'b00) begin
            sb.push_back('{NOP, pc, 1'b1, 1'b0});
            hold = 1'b1;
        end else begin
            while (!done && k < 20) begin
                @(negedge clock);
                idle_inputs();
                pc_valid = 1'($urandom_range(0, 1));
                pc_in    = $urandom;
                mem_ack  = (k == d);
                if (mem_ack) mem_rdata = rdata;
                flush = dropping ? 1'($urandom_range(0, 1)) : (k == f);
                #1;
                check("mem_req_busy", 32'(mem_req), 32'd1);
                check("mem_addr",     mem_addr,     pc);
                check("pc_ready_busy", 32'(pc_ready), 32'd0);
                if (!dropping) begin
                    if (flush && mem_ack) begin
                        done = 1'b1;
                    end else if (flush) begin
                        dropping = 1'b1;
                    end else if (mem_ack) begin
                        sb.push_back('{rdata, pc, 1'b0, 1'b0});
                        hold = 1'b1;
                        done = 1'b1;
                    end else if (k >= T - 1) begin
                        sb.push_back('{NOP, pc, 1'b0, 1'b1});
                        hold = 1'b1;
                        done = 1'b1;
                    end
                end else if (mem_ack || k >= T - 1) begin
                    done = 1'b1;
                end
                k++;
            end
            if (!done) begin
                tests++;
                fails++;
                $display("FAIL req_bound: got no exit after %0d cycles required exit by %0d", k, T + 1);
            end
        end
        if (hold) begin
            for (int i = 0; i <= rdelay; i++) begin
                @(negedge clock);
                idle_inputs();
                if (i == rdelay) begin
                    instr_ready = (rel != 1);
                    flush       = (rel != 0);
                end else begin
                    pc_valid = 1'($urandom_range(0, 1));
                end
                pc_in = $urandom;
                #1;
                check("mem_req_hold",  32'(mem_req),  32'd0);
                check("pc_ready_hold", 32'(pc_ready), 32'd0);
            end
        end
        @(negedge clock);
        idle_inputs();
        #1;
        check("mem_req_after",     32'(mem_req),     32'd0);
        check("instr_valid_after", 32'(instr_valid), 32'd0);
        check("pc_ready_after",    32'(pc_ready),    32'd1);
    endtask

    // Driver: directed cases first, then randomized fetches.
    initial begin
        reset_n = 1'b0;
        pc_in   = 32'd0;
        idle_inputs();
        repeat (3) @(negedge clock);
        #1;
        check("rst_mem_req",     32'(mem_req),     32'd0);
        check("rst_mem_addr",    mem_addr,         32'd0);
        check("rst_instr",       instr,            NOP);
        check("rst_instr_pc",    instr_pc,         32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_ready",    32'(pc_ready),    32'd1);
        reset_n = 1'b1;

        // Basic fetch with 5-cycle decoder back-pressure.
        run_txn(32'h0000_0100, 0, NEVER, 32'h00A0_0093, 5, 0, 1'b0);

        // Reset in the middle of a request.
        @(negedge clock);
        idle_inputs();
        pc_valid = 1'b1;
        pc_in    = 32'h0000_0200;
        @(negedge clock);
        idle_inputs();
        #1 check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midreq_rst_mem_req",     32'(mem_req),     32'd0);
        check("midreq_rst_instr_valid", 32'(instr_valid), 32'd0);
        check("midreq_rst_instr",       instr,            NOP);
        check("midreq_rst_instr_pc",    instr_pc,         32'd0);
        check("midreq_rst_pc_ready",    32'(pc_ready),    32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        run_txn(32'h0000_0102, 0,     NEVER, 32'h0,         2, 0, 1'b0); // misaligned
        run_txn(32'h0000_0180, 3,     1,     32'hDEAD_BEEF, 0, 0, 1'b0); // flush then late ack
        run_txn(32'h0000_01C0, 2,     2,     32'hCAFE_F00D, 0, 0, 1'b0); // flush with ack
        run_txn(32'h0000_0240, NEVER, NEVER, 32'h0,         1, 0, 1'b0); // timeout
        run_txn(32'h0000_0280, NEVER, T - 1, 32'h0,         0, 0, 1'b0); // flush on last cycle
        run_txn(32'h0000_02C0, T - 1, NEVER, 32'h1234_5678, 0, 2, 1'b1); // ack on last cycle
        run_txn(32'h0000_0300, 1,     NEVER, 32'h8765_4321, 3, 1, 1'b1); // flush releases hold

        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            int          f;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            f = ($urandom_range(0, 1) != 0) ? NEVER : int'($urandom_range(0, T));
            run_txn(pc, int'($urandom_range(0, T + 1)), f, $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the run never reaches its summary.
    initial begin
        #400000;
        $display("FAIL watchdog: got no completion required finish before %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting between the PC/branch stage and the decoder. It accepts a PC from the branch stage and issues a single-word read to instruction memory over a req/ack handshake. It holds the returned instruction, tagged with its PC, until the decoder consumes it. It also supports flush on redirect and a bounded memory-wait timeout; it is non-pipelined, with one fetch outstanding.

Parameters:
NOP_INSTR, 32'h00000013, instruction value driven on instr when no valid fetch data exists (addi x0,x0,0).
TIMEOUT_CYCLES, 255, max cycles spent in REQ waiting for mem_ack before aborting with fetch_error; legal range 1..255.

Ports:
clock  input  1  system clock, all state updates on posedge.
reset_n  input  1  asynchronous active-low reset.
pc_in  input  32  fetch address from branch stage.
pc_valid  input  1  pc_in is valid this cycle.
pc_ready  output  1  fetch accepts pc_in this cycle (combinational: state==IDLE && !flush).
flush  input  1  redirect; discard in-flight/held instruction.
mem_req  output  1  memory read request.
mem_addr  output  32  memory word address (byte address, [1:0]==0).
mem_ack  input  1  memory response valid; mem_rdata sampled same edge.
mem_rdata  input  32  memory read data.
instr  output  32  fetched instruction.
instr_pc  output  32  PC of instr.
instr_valid  output  1  instr/instr_pc valid for decoder.
instr_ready  input  1  decoder consumes instr this cycle.
misaligned  output  1  held entry is a misaligned-PC fault.
fetch_error  output  1  held entry is a memory-timeout fault.

Behaviour:
- Reset (async, reset_n low): state=IDLE; mem_req=0, mem_addr=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, misaligned=0, fetch_error=0, timer=0. Reset mid-REQ abandons the request immediately; memory must tolerate mem_req dropping.
- All outputs except pc_ready are registered.
- States: IDLE, REQ, HOLD, DROP.
- IDLE, transfer = pc_valid && pc_ready:
  - pc_in[1:0]!=0: go to HOLD with instr=NOP_INSTR, instr_pc=pc_in, misaligned=1, instr_valid=1; no memory access.
  - Otherwise: mem_req<=1, mem_addr<=pc_in, instr_pc<=pc_in, timer<=0, go to REQ.
- flush in IDLE: pc_valid ignored that cycle.
- REQ:
  - mem_req=1 and mem_addr held stable until ack.
  - On mem_ack: instr<=mem_rdata, instr_valid<=1, misaligned=0, fetch_error=0, mem_req<=0, go to HOLD.
  - No ack: timer+1 (8-bit, saturating). If timer==TIMEOUT_CYCLES-1 on a non-ack cycle: mem_req<=0, instr=NOP_INSTR, fetch_error=1, instr_valid=1, go to HOLD.
  - flush && mem_ack same cycle: data discarded, mem_req<=0, go to IDLE.
  - flush without ack: go to DROP, mem_req stays 1.
  - flush has priority over timeout.
- HOLD:
  - instr, instr_pc, misaligned, fetch_error stable while instr_valid=1.
  - instr_ready: instr_valid<=0, flags<=0, go to IDLE.
  - flush: same as instr_ready. flush && instr_ready together counts as a single exit.
- DROP:
  - mem_req=1 until mem_ack; on ack, data discarded, mem_req<=0, go to IDLE.
  - flush ignored in DROP.
  - Timeout applies as in REQ, but returns to IDLE with no HOLD entry.
- Latency: pc accepted at edge N gives mem_req high after N; earliest ack at N+1 gives instr_valid after N+1. Minimum 3 cycles per instruction (IDLE, REQ, HOLD) with instr_ready tied high.
- instr keeps its last value after consumption; consumers must qualify it with instr_valid.

Test Plan:
- Reset: reset_n low mid-REQ -> next cycle mem_req=0, instr_valid=0, instr=32'h00000013, pc_ready=1.
- Basic fetch: pc_in=0x100, pc_valid=1; ack one cycle later with rdata=0x00A00093 -> mem_addr=0x100 during REQ, then instr=0x00A00093, instr_pc=0x100, instr_valid=1; instr_ready=1 -> IDLE next cycle.
- Backpressure: instr_ready=0 for 5 cycles after valid -> instr/instr_pc stable, pc_ready=0; pc_valid pulses ignored.
- Misaligned: pc_in=0x102 -> no mem_req; instr_valid=1, misaligned=1, instr=NOP, instr_pc=0x102.
- Flush in REQ: flush at cycle 1 of REQ, ack at cycle 3 with rdata=0xDEADBEEF -> DROP holds mem_req until ack; no instr_valid; IDLE after ack. Separately, flush coinciding with ack -> IDLE, no instr_valid.
- Timeout: TIMEOUT_CYCLES=4, ack never asserted -> mem_req high exactly 4 cycles, then instr_valid=1, fetch_error=1, instr=NOP.
